// File: rtl/bist_signature_checker.sv
// BIST response compactor: folds CUT responses into a MISR while the controller runs,
// then grades the signature and capture count against golden values and latches PASS/FAIL.
module bist_signature_checker #(
  parameter int unsigned    W         = 16,
  parameter logic [W-1:0]   POLY      = 16'h1021,
  parameter logic [W-1:0]   SEED      = 16'h0000,
  parameter logic [W-1:0]   GOLDEN    = 16'h0000,
  parameter int unsigned    CNT_W     = 10,
  parameter int unsigned    EXP_CNT   = 990,
  parameter bit             CHECK_CNT = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             INIT,
  input  logic             EN,
  input  logic             FINISH,
  input  logic [W-1:0]     DATA_IN,
  output logic [W-1:0]     SIGNATURE,
  output logic [CNT_W-1:0] CAP_CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMPARE,
    S_RESULT
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  logic [W-1:0]     misr_next;
  logic             good;

  // Shift drops the MSB; when it was set, the implicit x^W term folds back in as POLY.
  assign misr_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ DATA_IN;

  assign good = (sig_q == GOLDEN) &&
                (!CHECK_CNT || (cnt_q == CNT_W'(EXP_CNT)));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;

    if (INIT) begin
      // INIT overrides everything, including a same-cycle EN sample or FINISH.
      state_d = S_ACCUM;
      sig_d   = SEED;
      cnt_d   = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (EN) begin
            sig_d = misr_next;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
          if (FINISH) state_d = S_COMPARE;
        end
        S_COMPARE: begin
          pass_d  = good;
          fail_d  = !good;
          state_d = S_RESULT;
        end
        S_IDLE, S_RESULT: state_d = state_q;
        default:          state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values they held before the edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign SIGNATURE = sig_q;
  assign CAP_CNT   = cnt_q;
  assign BUSY      = (state_q == S_ACCUM);
  assign DONE      = (state_q == S_RESULT);
  assign PASS      = pass_q;
  assign FAIL      = fail_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Self-checking bench for bist_signature_checker: directed scenarios on small 4-bit
// instances plus randomized capture windows graded against a polynomial-arithmetic model.
module tb_bist_signature_checker;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        en;
  logic        finish;
  logic [15:0] data;

  logic [3:0]  sig_a, sig_b, sig_c, sig_s;
  logic [15:0] sig_r;
  logic [9:0]  cnt_a, cnt_b, cnt_c, cnt_r;
  logic [2:0]  cnt_s;
  logic        busy_a, done_a, pass_a, fail_a;
  logic        busy_b, done_b, pass_b, fail_b;
  logic        busy_c, done_c, pass_c, fail_c;
  logic        busy_s, done_s, pass_s, fail_s;
  logic        busy_r, done_r, pass_r, fail_r;

  int n_vec = 0;
  int n_err = 0;
  int unsigned caps[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bist_signature_checker #(.W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h3),
                           .CNT_W(10), .EXP_CNT(3), .CHECK_CNT(1'b1)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .INIT(init), .EN(en), .FINISH(finish), .DATA_IN(data[3:0]),
    .SIGNATURE(sig_a), .CAP_CNT(cnt_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .FAIL(fail_a));

  bist_signature_checker #(.W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h6),
                           .CNT_W(10), .EXP_CNT(3), .CHECK_CNT(1'b1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .INIT(init), .EN(en), .FINISH(finish), .DATA_IN(data[3:0]),
    .SIGNATURE(sig_b), .CAP_CNT(cnt_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .FAIL(fail_b));

  bist_signature_checker #(.W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h6),
                           .CNT_W(10), .EXP_CNT(3), .CHECK_CNT(1'b0)) dut_c (
    .CLK(clk), .RESET_N(rst_n), .INIT(init), .EN(en), .FINISH(finish), .DATA_IN(data[3:0]),
    .SIGNATURE(sig_c), .CAP_CNT(cnt_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .FAIL(fail_c));

  bist_signature_checker #(.W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h3),
                           .CNT_W(3), .EXP_CNT(3), .CHECK_CNT(1'b1)) dut_s (
    .CLK(clk), .RESET_N(rst_n), .INIT(init), .EN(en), .FINISH(finish), .DATA_IN(data[3:0]),
    .SIGNATURE(sig_s), .CAP_CNT(cnt_s), .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .FAIL(fail_s));

  bist_signature_checker dut_r (
    .CLK(clk), .RESET_N(rst_n), .INIT(init), .EN(en), .FINISH(finish), .DATA_IN(data),
    .SIGNATURE(sig_r), .CAP_CNT(cnt_r), .BUSY(busy_r), .DONE(done_r), .PASS(pass_r), .FAIL(fail_r));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signature as repeated multiply-by-x modulo (x^w + poly) over GF(2), plus each sample.
  function automatic int unsigned model_sig(int unsigned w, int unsigned poly, int unsigned seed);
    int unsigned top = 1 << w;
    int unsigned s   = seed;
    foreach (caps[i]) begin
      s = s * 2;
      if (s >= top) s = (s - top) ^ poly;
      s = s ^ (caps[i] % top);
    end
    return s;
  endfunction

  function automatic int unsigned model_cnt(int unsigned cnt_w);
    int unsigned lim = (1 << cnt_w) - 1;
    return (caps.size() > lim) ? lim : caps.size();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1; en = 1'b0; finish = 1'b0;
    step();
    init = 1'b0;
  endtask

  task automatic capture(input logic [15:0] d);
    en = 1'b1; data = d;
    step();
    en = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; en = 1'b0; finish = 1'b0; data = '0;
    #12;
    check("reset_a_sig", sig_a, 4'h0);
    check("reset_a_cnt", cnt_a, 0);
    check("reset_a_flags", {busy_a, done_a, pass_a, fail_a}, 4'b0000);
    check("reset_r_flags", {sig_r, cnt_r, busy_r, done_r, pass_r, fail_r}, 0);
    rst_n = 1'b1;
    step();

    // Basic pass: 1,2,3 -> signature 1,0,3
    do_init();
    check("init_busy", {busy_a, done_a}, 2'b10);
    capture(16'h1); check("basic_sig1", sig_a, 4'h1);
    capture(16'h2); check("basic_sig2", sig_a, 4'h0);
    capture(16'h3); check("basic_sig3", sig_a, 4'h3);
    check("basic_cnt", cnt_a, 3);
    finish = 1'b1; step(); finish = 1'b0;
    check("compare_flags", {busy_a, done_a, pass_a, fail_a}, 4'b0000);
    step();
    check("basic_result", {busy_a, done_a, pass_a, fail_a}, 4'b0110);

    // Count mismatch: fourth sample -> signature 6, count 4
    do_init();
    capture(16'h1); capture(16'h2); capture(16'h3); capture(16'h0);
    check("cnt4_sig", sig_a, 4'h6);
    check("cnt4_cnt", cnt_a, 4);
    do_finish();
    check("cnt4_a", {done_a, pass_a, fail_a}, 3'b101);
    check("cnt4_b", {sig_b, cnt_b, done_b, pass_b, fail_b}, {4'h6, 10'd4, 3'b101});
    check("cnt4_c", {sig_c, cnt_c, done_c, pass_c, fail_c}, {4'h6, 10'd4, 3'b110});
    check("cnt4_busy", {busy_a, busy_b, busy_c}, 3'b000);

    // Signature error, then hold under EN/FINISH noise
    do_init();
    capture(16'h1); capture(16'h2); capture(16'h2);
    check("sigerr_sig", sig_a, 4'h2);
    do_finish();
    check("sigerr_flags", {done_a, pass_a, fail_a}, 3'b101);
    for (int i = 0; i < 50; i++) begin
      en = 1'($urandom); finish = 1'($urandom); data = 16'($urandom);
      step();
      check("hold", {done_a, pass_a, fail_a, sig_a, cnt_a}, {3'b101, 4'h2, 10'd3});
    end
    en = 1'b0; finish = 1'b0;

    // EN and FINISH coincident: last sample included
    do_init();
    capture(16'h1); capture(16'h2);
    en = 1'b1; data = 16'h3; finish = 1'b1;
    step();
    en = 1'b0; finish = 1'b0;
    check("coinc_cmp", {done_a, sig_a, cnt_a}, {1'b0, 4'h3, 10'd3});
    step();
    check("coinc_result", {done_a, pass_a, fail_a}, 3'b110);

    // Re-INIT from RESULT with an EN sample in the INIT cycle
    init = 1'b1; en = 1'b1; data = 16'h5;
    step();
    init = 1'b0; en = 1'b0;
    check("reinit_result", {busy_a, done_a, pass_a, fail_a, sig_a, cnt_a}, {4'b1000, 4'h0, 10'd0});

    // Re-INIT mid-ACCUM
    capture(16'h1); capture(16'h2);
    init = 1'b1; en = 1'b1; data = 16'h7;
    step();
    init = 1'b0; en = 1'b0;
    check("reinit_accum", {busy_a, done_a, sig_a, cnt_a}, {2'b10, 4'h0, 10'd0});

    // INIT and FINISH together: INIT wins, no compare follows
    init = 1'b1; finish = 1'b1;
    step();
    init = 1'b0; finish = 1'b0;
    check("init_fin_busy", {busy_a, done_a}, 2'b10);
    step(); step();
    check("init_fin_late", {busy_a, done_a, pass_a, fail_a}, 4'b1000);

    // Async reset mid-ACCUM, between clock edges
    capture(16'h5);
    check("pre_rst", {sig_a, cnt_a}, {4'h5, 10'd1});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {busy_a, done_a, pass_a, fail_a, sig_a, cnt_a}, {4'b0000, 4'h0, 10'd0});
    #2 rst_n = 1'b1;
    finish = 1'b1; step(); finish = 1'b0;
    step(); step();
    check("idle_finish", {busy_a, done_a, pass_a, fail_a}, 4'b0000);
    capture(16'h3);
    check("idle_en", {sig_a, cnt_a}, {4'h0, 10'd0});

    // Saturation on the 3-bit counter
    do_init();
    caps.delete();
    for (int i = 0; i < 10; i++) begin
      capture(16'(i + 1));
      caps.push_back(i + 1);
    end
    check("sat_cnt_s", cnt_s, 7);
    check("sat_cnt_a", cnt_a, 10);
    check("sat_sig_s", sig_s, model_sig(4, 3, 0));
    check("sat_busy_s", busy_s, 1'b1);

    // Randomized capture windows against the reference model
    for (int run = 0; run < 8; run++) begin
      int unsigned n;
      do_init();
      caps.delete();
      n = $urandom_range(4, 60);
      for (int i = 0; i < int'(n); i++) begin
        en = 1'($urandom_range(0, 3) != 0);
        data = 16'($urandom);
        finish = (i == int'(n) - 1);
        step();
        if (en) caps.push_back(data);
        check("rnd_sig_r", sig_r, model_sig(16, 32'h1021, 0));
        check("rnd_cnt_r", cnt_r, model_cnt(10));
        check("rnd_sig_a", sig_a, model_sig(4, 3, 0));
        check("rnd_cnt_s", cnt_s, model_cnt(3));
      end
      en = 1'b0; finish = 1'b0;
      step();
      begin
        logic good_r, good_a, good_c;
        good_r = (model_sig(16, 32'h1021, 0) == 0) && (caps.size() == 990);
        good_a = (model_sig(4, 3, 0) == 3) && (caps.size() == 3);
        good_c = (model_sig(4, 3, 0) == 6);
        check("rnd_res_r", {busy_r, done_r, pass_r, fail_r}, {2'b01, good_r, !good_r});
        check("rnd_res_a", {done_a, pass_a, fail_a}, {1'b1, good_a, !good_a});
        check("rnd_res_c", {done_c, pass_c, fail_c}, {1'b1, good_c, !good_c});
        check("rnd_excl_s", {done_s, pass_s & fail_s}, 2'b10);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
